// File: rtl/pico_int_pkg.sv
// Shared definitions for the picoProcessor interrupt controller: register map,
// CTRL/VEC bit positions, FSM encoding and the priority encoder.
package pico_int_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_VEC  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_EOI = 7;
  localparam int VEC_VLD  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  // Index 0 is the highest priority, so the lowest set bit wins.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/pico_int_controller_if.sv
// Processor-side bundle: int_req/int_ack handshake plus the port bus.
// master = processor, slave = interrupt controller.
interface pico_int_controller_if;

  logic       pico_int_req;
  logic       pico_int_ack;
  logic [7:0] pico_port_address;
  logic       pico_port_read;
  logic       pico_port_write;
  logic [7:0] pico_port_wdata;
  logic [7:0] pico_port_rdata;
  logic       pico_port_rdata_oe;
  logic       pico_port_ready;

  modport master (
    input  pico_int_req, pico_port_rdata, pico_port_rdata_oe, pico_port_ready,
    output pico_int_ack, pico_port_address, pico_port_read, pico_port_write,
           pico_port_wdata
  );

  modport slave (
    output pico_int_req, pico_port_rdata, pico_port_rdata_oe, pico_port_ready,
    input  pico_int_ack, pico_port_address, pico_port_read, pico_port_write,
           pico_port_wdata
  );

endinterface

// File: rtl/pico_irq_sync_edge.sv
// Per-source synchroniser followed by a rising-edge detector.
// Latency: rise asserts SYNC_STAGES cycles after the input edge; no backpressure.
module pico_irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pico_clk,
  input  logic pico_reset,
  input  logic irq,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge pico_clk or posedge pico_reset) begin
    if (pico_reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], irq};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/pico_int_controller.sv
// Priority interrupt controller: PEND/MASK/VEC/CTRL registers, request FSM.
// Latency: edge->PEND SYNC_STAGES+1 cycles, port ready one cycle after strobe; no backpressure.
module pico_int_controller
  import pico_int_pkg::*;
#(
  parameter int         NUM_SRC     = 8,
  parameter logic [7:0] BASE_ADDR   = 8'hF0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               pico_clk,
  input  logic               pico_reset,
  input  logic [NUM_SRC-1:0] irq_src,
  pico_int_controller_if.slave bus
);

  logic [NUM_SRC-1:0] rise, pend, pend_n, mask, act;
  logic [7:0]         pend8, mask8, act8, rd_val;
  logic               en, vec_vld, hit, wr, rd, eoi, take;
  logic [2:0]         vec_idx, win;
  logic [1:0]         off;
  state_t             state, state_n;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    pico_irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .pico_clk  (pico_clk),
      .pico_reset(pico_reset),
      .irq       (irq_src[i]),
      .rise      (rise[i])
    );
  end

  // A simultaneous read+write is handled as a write only.
  assign hit  = (bus.pico_port_address[7:2] == BASE_ADDR[7:2]);
  assign off  = bus.pico_port_address[1:0];
  assign wr   = bus.pico_port_write & hit;
  assign rd   = bus.pico_port_read & ~bus.pico_port_write & hit;
  assign eoi  = wr && (off == REG_CTRL) && bus.pico_port_wdata[CTRL_EOI];
  assign act  = pend & mask;
  assign win  = lowest_set(act8);
  assign take = (state == ST_REQ) && (state_n == ST_SERV);

  assign bus.pico_int_req = (state == ST_REQ);

  always_comb begin
    pend8 = '0;
    mask8 = '0;
    act8  = '0;
    pend8[NUM_SRC-1:0] = pend;
    mask8[NUM_SRC-1:0] = mask;
    act8[NUM_SRC-1:0]  = act;
  end

  always_comb begin
    rd_val = 8'h00;
    case (off)
      REG_PEND: rd_val = pend8;
      REG_MASK: rd_val = mask8;
      REG_VEC:  rd_val = {vec_vld, 4'b0000, vec_idx};
      REG_CTRL: rd_val = {7'b0000000, en};
      default:  rd_val = 8'h00;
    endcase
  end

  // New edges are applied last so they win over W1C and the ack-time clear.
  always_comb begin
    pend_n = pend;
    if (wr && (off == REG_PEND)) pend_n = pend_n & ~bus.pico_port_wdata[NUM_SRC-1:0];
    if (take) pend_n = pend_n & ~(NUM_SRC'(1) << win);
    pend_n = pend_n | rise;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (en && (act != '0)) state_n = ST_REQ;
      ST_REQ: begin
        if (!en || (act == '0))     state_n = ST_IDLE;
        else if (bus.pico_int_ack)  state_n = ST_SERV;
      end
      ST_SERV: if (eoi) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge pico_clk or posedge pico_reset) begin
    if (pico_reset) begin
      state                  <= ST_IDLE;
      pend                   <= '0;
      mask                   <= '0;
      en                     <= 1'b0;
      vec_vld                <= 1'b0;
      vec_idx                <= 3'd0;
      bus.pico_port_rdata    <= 8'h00;
      bus.pico_port_rdata_oe <= 1'b0;
      bus.pico_port_ready    <= 1'b0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      if (wr && (off == REG_MASK)) mask <= bus.pico_port_wdata[NUM_SRC-1:0];
      if (wr && (off == REG_CTRL)) en <= bus.pico_port_wdata[CTRL_EN];
      if (take) begin
        vec_vld <= 1'b1;
        vec_idx <= win;
      end else if ((state == ST_SERV) && eoi) begin
        vec_vld <= 1'b0;
        vec_idx <= 3'd0;
      end
      bus.pico_port_rdata    <= rd ? rd_val : 8'h00;
      bus.pico_port_rdata_oe <= rd;
      bus.pico_port_ready    <= rd | wr;
    end
  end

endmodule

// File: tb/tb_pico_int_controller.sv
// Directed bench for pico_int_controller: register vector table plus
// hand-written interrupt handshake sequences.
module tb_pico_int_controller;

  logic       pico_clk;
  logic       pico_reset;
  logic [7:0] irq_src;
  int         checks;
  int         failures;

  pico_int_controller_if bus ();

  pico_int_controller #(
    .NUM_SRC(8), .BASE_ADDR(8'hF0), .SYNC_STAGES(2)
  ) dut (
    .pico_clk  (pico_clk),
    .pico_reset(pico_reset),
    .irq_src   (irq_src),
    .bus       (bus.slave)
  );

  initial pico_clk = 1'b0;
  always #5 pico_clk = ~pico_clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_rdy;
    logic       exp_oe;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Strobe set after a falling edge, sampled at the next rising edge;
  // registered response is observed at the following falling edge.
  task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] q, output logic rdy, output logic oe);
    bus.pico_port_address = a;
    bus.pico_port_wdata   = d;
    bus.pico_port_read    = r;
    bus.pico_port_write   = w;
    @(negedge pico_clk);
    bus.pico_port_read  = 1'b0;
    bus.pico_port_write = 1'b0;
    q   = bus.pico_port_rdata;
    rdy = bus.pico_port_ready;
    oe  = bus.pico_port_rdata_oe;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] q;
    logic       rdy, oe;
    access(1'b1, 1'b0, a, 8'h00, q, rdy, oe);
    chk(name, q, exp);
    chk1({name, "_ready"}, rdy, 1'b1);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] q;
    logic       rdy, oe;
    access(1'b0, 1'b1, a, d, q, rdy, oe);
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_src = m;
    @(negedge pico_clk);
    irq_src = 8'h00;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (bus.pico_int_req !== 1'b1 && n < 30) begin
      @(negedge pico_clk);
      n++;
    end
    chk1({name, "_req_timeout"}, bus.pico_int_req, 1'b1);
  endtask

  task automatic ack_once();
    bus.pico_int_ack = 1'b1;
    @(negedge pico_clk);
    bus.pico_int_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] q;
    logic       rdy, oe;
    checks   = 0;
    failures = 0;
    pico_reset            = 1'b1;
    irq_src               = 8'h00;
    bus.pico_int_ack      = 1'b0;
    bus.pico_port_address = 8'h00;
    bus.pico_port_read    = 1'b0;
    bus.pico_port_write   = 1'b0;
    bus.pico_port_wdata   = 8'h00;

    //               rd    wr    addr   wdata  rdata  rdy   oe
    tbl[0]  = '{1'b1, 1'b0, 8'hF1, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8'hEF, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'hF4, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'hF1, 8'hFF, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'hF1, 8'h00, 8'hFF, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'hF1, 8'h5A, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'hF1, 8'h00, 8'h5A, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'hF2, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'hF2, 8'hFF, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'hF2, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 8'hF3, 8'h81, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'hF3, 8'h00, 8'h01, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 8'hF1, 8'h33, 8'h00, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'hF1, 8'h00, 8'h33, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 8'hF3, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'hF3, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 8'hF1, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b1};

    repeat (3) @(negedge pico_clk);
    chk1("rst_int_req", bus.pico_int_req, 1'b0);
    chk("rst_rdata", bus.pico_port_rdata, 8'h00);
    chk1("rst_oe", bus.pico_port_rdata_oe, 1'b0);
    chk1("rst_ready", bus.pico_port_ready, 1'b0);
    pico_reset = 1'b0;
    @(negedge pico_clk);

    for (int i = 0; i < 18; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, q, rdy, oe);
      chk($sformatf("vec%0d_rdata", i), q, tbl[i].exp_rdata);
      chk1($sformatf("vec%0d_ready", i), rdy, tbl[i].exp_rdy);
      chk1($sformatf("vec%0d_oe", i), oe, tbl[i].exp_oe);
    end
    @(negedge pico_clk);
    chk1("ready_one_cycle", bus.pico_port_ready, 1'b0);
    chk1("oe_one_cycle", bus.pico_port_rdata_oe, 1'b0);

    // Masked, disabled source: pending only; ack outside REQ ignored.
    pulse(8'h01);
    repeat (2) @(negedge pico_clk);
    rd_chk("idle_pend", 8'hF0, 8'h01);
    chk1("idle_no_req", bus.pico_int_req, 1'b0);
    ack_once();
    rd_chk("idle_ack_vec", 8'hF2, 8'h00);
    rd_chk("idle_ack_pend", 8'hF0, 8'h01);
    wr_reg(8'hF0, 8'h01);
    rd_chk("w1c_pend", 8'hF0, 8'h00);

    // Single source 2.
    wr_reg(8'hF1, 8'h04);
    wr_reg(8'hF3, 8'h01);
    pulse(8'h04);
    repeat (2) @(negedge pico_clk);
    chk1("t2_req_before", bus.pico_int_req, 1'b0);
    rd_chk("t2_pend", 8'hF0, 8'h04);
    chk1("t2_req", bus.pico_int_req, 1'b1);
    ack_once();
    chk1("t2_req_after_ack", bus.pico_int_req, 1'b0);
    rd_chk("t2_vec", 8'hF2, 8'h82);
    rd_chk("t2_pend_clr", 8'hF0, 8'h00);
    wr_reg(8'hF3, 8'h81);
    rd_chk("t2_vec_eoi", 8'hF2, 8'h00);
    rd_chk("t2_ctrl", 8'hF3, 8'h01);

    // Priority between sources 5 and 1.
    wr_reg(8'hF1, 8'hFF);
    pulse(8'h22);
    wait_req("t3a");
    ack_once();
    rd_chk("t3_vec1", 8'hF2, 8'h81);
    rd_chk("t3_pend", 8'hF0, 8'h20);
    chk1("t3_serv_no_req", bus.pico_int_req, 1'b0);
    wr_reg(8'hF3, 8'h81);
    wait_req("t3b");
    ack_once();
    rd_chk("t3_vec5", 8'hF2, 8'h85);
    wr_reg(8'hF3, 8'h81);
    rd_chk("t3_pend_end", 8'hF0, 8'h00);

    // Late higher-priority winner during REQ.
    pulse(8'h08);
    wait_req("t4a");
    pulse(8'h01);
    repeat (2) @(negedge pico_clk);
    ack_once();
    rd_chk("t4_vec", 8'hF2, 8'h80);
    rd_chk("t4_pend", 8'hF0, 8'h08);
    wr_reg(8'hF3, 8'h81);
    wait_req("t4b");
    ack_once();
    rd_chk("t4_vec3", 8'hF2, 8'h83);
    wr_reg(8'hF3, 8'h81);

    // Withdrawal by W1C while in REQ.
    wr_reg(8'hF1, 8'h08);
    pulse(8'h08);
    wait_req("t5a");
    wr_reg(8'hF0, 8'h08);
    @(negedge pico_clk);
    chk1("t5_withdrawn", bus.pico_int_req, 1'b0);
    rd_chk("t5_pend", 8'hF0, 8'h00);
    rd_chk("t5_vec", 8'hF2, 8'h00);

    // Same-cycle edge and W1C on bit 6: set wins.
    wr_reg(8'hF1, 8'hFF);
    pulse(8'h40);
    @(negedge pico_clk);
    wr_reg(8'hF0, 8'h40);
    rd_chk("t5_collide", 8'hF0, 8'h40);
    wait_req("t5b");
    ack_once();
    rd_chk("t5_vec6", 8'hF2, 8'h86);

    // EN cleared in SERV keeps service; then asynchronous reset mid-read.
    wr_reg(8'hF3, 8'h00);
    rd_chk("t6_vec_en0", 8'hF2, 8'h86);
    access(1'b1, 1'b0, 8'hF2, 8'h00, q, rdy, oe);
    chk("t6_pre_rst_rdata", q, 8'h86);
    pico_reset = 1'b1;
    #1;
    chk1("t6_rst_req", bus.pico_int_req, 1'b0);
    chk("t6_rst_rdata", bus.pico_port_rdata, 8'h00);
    chk1("t6_rst_ready", bus.pico_port_ready, 1'b0);
    chk1("t6_rst_oe", bus.pico_port_rdata_oe, 1'b0);
    repeat (2) @(negedge pico_clk);
    pico_reset = 1'b0;
    @(negedge pico_clk);
    rd_chk("t6_vec", 8'hF2, 8'h00);
    rd_chk("t6_mask", 8'hF1, 8'h00);
    rd_chk("t6_ctrl", 8'hF3, 8'h00);
    rd_chk("t6_pend", 8'hF0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pico_int_controller.md
Name: pico_int_controller

Overview:
Priority interrupt controller that collects up to NUM_SRC asynchronous interrupt sources and sequences the picoProcessor's single int_req/int_ack handshake. It holds one request in service until the handler writes end-of-interrupt (EOI). Software reaches its pending, mask, vector and control registers through the processor's port bus at BASE_ADDR..BASE_ADDR+3. It sits beside the processor in the board-level top.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..8); index 0 has the highest priority.
BASE_ADDR, 8'hF0, port address of register 0; must be 4-aligned.
SYNC_STAGES, 2, synchroniser depth per source (minimum 2).

Ports:
pico_clk  in  1  single system clock; all state is on its rising edge.
pico_reset  in  1  reset, asynchronous and active-high; clears all state.
irq_src  in  NUM_SRC  asynchronous interrupt lines; a rising edge requests service.
pico_int_req  out  1  interrupt request to the processor.
pico_int_ack  in  1  acknowledge from the processor.
pico_port_address  in  8  processor port address.
pico_port_read  in  1  port read strobe.
pico_port_write  in  1  port write strobe.
pico_port_wdata  in  8  write data, taken from the processor port bus.
pico_port_rdata  out  8  read data; 8'h00 when not driving.
pico_port_rdata_oe  out  1  read-data enable for the top-level tri-state on the port data bus.
pico_port_ready  out  1  access-complete pulse for this block's addresses.

Behaviour:
- Reset values: pico_int_req=0, pico_port_rdata=0, pico_port_rdata_oe=0, pico_port_ready=0. Registers: PEND=0, MASK=0 (all sources masked), VEC=0, CTRL.EN=0. FSM=IDLE. Synchroniser flops=0.
- Source path: SYNC_STAGES-flop synchroniser, then a rising-edge detector (current sync level 1, previous 0). A detected edge sets PEND[i] on the next edge. Total latency from input edge to PEND visible is SYNC_STAGES+1 cycles.
- Register map (offset from BASE_ADDR):
  - 0 PEND: read returns pending bits; write-1-to-clear.
  - 1 MASK: read/write; 1 = source enabled.
  - 2 VEC: read-only in-service vector. {1'b1, 4'b0, idx[2:0]} while a source is in service, else 8'h00.
  - 3 CTRL: bit0 EN is read/write. Writing 1 to bit7 is EOI; bit7 is self-clearing and reads back 0.
- Unused register bits (above NUM_SRC) read 0 and ignore writes.
- Port access: a read or write strobe with address in range is sampled on the clock edge.
  - Writes take effect on that same edge.
  - On the following cycle, pico_port_ready=1 for exactly one cycle. For reads, pico_port_rdata holds the value sampled at the strobe edge and pico_port_rdata_oe=1 in that cycle only.
  - Out-of-range addresses produce no response at all.
  - Read and write both asserted in the same cycle: treated as a write.
- FSM:
  - IDLE: go to REQ when EN and |(PEND & MASK).
  - REQ: pico_int_req=1. On pico_int_ack=1: latch the lowest set index of (PEND & MASK) into VEC, clear that PEND bit, deassert int_req on the next cycle, go to SERV.
  - REQ: if EN drops or (PEND & MASK) becomes 0 before ack (clear or mask by software), deassert int_req and return to IDLE.
  - SERV: int_req=0; other pending sources wait. An EOI write clears VEC and returns to IDLE. A new request can assert no earlier than the cycle after IDLE is re-entered.
- The winner is chosen at the ack edge, not at request time, so a higher-priority edge arriving during REQ wins.
- pico_int_ack outside REQ is ignored.
- Same-cycle edge detection and W1C on the same PEND bit: set wins.
- Same-cycle edge on the source being cleared at the ack edge: the bit stays set (new request).
- EOI while in IDLE or REQ: no effect.
- Clearing EN in SERV: no effect on the in-service state; EOI is still required.
- pico_reset asserted mid-handshake: all outputs go to reset values immediately (asynchronously); any in-flight ack is lost.

Decomposition:
- Shared package pico_int_pkg: register offset constants (PEND=0, MASK=1, VEC=2, CTRL=3), CTRL bit positions (EN=0, EOI=7), VEC valid bit (7), and the FSM state encoding (IDLE, REQ, SERV).
- One natural sub-module, pico_irq_sync_edge: the per-source synchroniser and rising-edge detector, instantiated NUM_SRC times.
- Priority encoder, register file and FSM stay in the top module.

Test Plan:
1. Reset values: after reset all outputs are 0. Read of BASE+1 returns 8'h00 with ready=1 and oe=1 one cycle after the strobe; read of 8'hEF gives no ready.
2. Single source: MASK=8'h04, CTRL=8'h01, pulse irq_src[2]. Expect PEND=8'h04 after 3 cycles and int_req=1 in the next cycle. On ack, VEC reads 8'h82 and PEND reads 8'h00. Write CTRL=8'h81 (EOI); VEC then reads 8'h00.
3. Priority: MASK=8'hFF, EN=1, edges on sources 5 and 1 in the same cycle. First ack gives VEC=8'h81; after EOI the second request gives VEC=8'h85.
4. Late winner: while in REQ for source 3, an edge on source 0 lands before the ack. Ack latches VEC=8'h80; PEND keeps bit 3 set.
5. Withdrawal and collision: in REQ, write PEND=8'h08 (W1C) with only source 3 pending; int_req drops and the FSM returns to IDLE. Separately, a same-cycle edge and W1C on bit 6 leaves PEND[6]=1.
6. Reset mid-operation: assert pico_reset in SERV. int_req=0 and VEC=0 immediately; MASK=8'h00 and EN=0 after release.
